// File: rtl/apb_ram_arbiter_if.sv
// Client request/response channels plus the shared APB bus for apb_ram_arbiter.
// The arbiter connects through the slave modport; clients and the APB slave use master.
interface apb_ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req0_ready;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          rsp0_err;

    logic          req1_valid;
    logic          req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          req1_ready;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          rsp1_err;

    logic [AW-1:0] paddr;
    logic          wr_en;
    logic          psel;
    logic          pen;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pselverr;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output paddr, wr_en, psel, pen, pwdata,
        input  prdata, pready, pselverr
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  paddr, wr_en, psel, pen, pwdata,
        output prdata, pready, pselverr
    );
endinterface

// File: rtl/apb_ram_arbiter.sv
// Round-robin arbiter sharing one APB slave between two valid/ready clients,
// with a programmable pready timeout so a hung slave cannot stall both clients.
module apb_ram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    apb_ram_arbiter_if.slave bus
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_LIMIT = (CW + 1)'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t r_state, w_next;

    logic [1:0]         w_req_valid;
    logic [1:0]         w_req_write;
    logic [1:0][AW-1:0] w_req_addr;
    logic [1:0][DW-1:0] w_req_wdata;

    logic               r_last_grant;
    logic               r_gnt;
    logic [CW-1:0]      r_wait;
    logic [AW-1:0]      r_paddr;
    logic               r_wr_en;
    logic [DW-1:0]      r_pwdata;
    logic               r_psel;
    logic               r_pen;
    logic [1:0]         r_rsp_valid;
    logic [1:0]         r_rsp_err;
    logic [1:0][DW-1:0] r_rsp_rdata;

    logic               w_grant;
    logic               w_accept;
    logic [CW:0]        w_wait_nxt;
    logic               w_timeout;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};
    assign w_req_write = {bus.req1_write, bus.req0_write};
    assign w_req_addr  = {bus.req1_addr,  bus.req0_addr};
    assign w_req_wdata = {bus.req1_wdata, bus.req0_wdata};

    // A lone requester wins outright; on a tie the client not served last wins.
    always_comb begin
        w_grant = w_req_valid[1];
        if (w_req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end
    end

    assign w_accept       = (r_state == S_IDLE) && (|w_req_valid);
    assign bus.req0_ready = w_accept && !w_grant;
    assign bus.req1_ready = w_accept && w_grant;

    // r_wait counts completed ACCESS cycles without pready; the timeout fires
    // in the cycle that would make the count reach TIMEOUT.
    assign w_wait_nxt = {1'b0, r_wait} + {{CW{1'b0}}, 1'b1};
    assign w_timeout  = (TIMEOUT != 0) && (w_wait_nxt == TO_LIMIT);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (bus.pready || w_timeout) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // psel/pen and the response pulse are registered off the next state so
    // they line up exactly with the SETUP/ACCESS/RESP cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_wait       <= '0;
            r_paddr      <= '0;
            r_wr_en      <= 1'b0;
            r_pwdata     <= '0;
            r_psel       <= 1'b0;
            r_pen        <= 1'b0;
            r_rsp_valid  <= '0;
            r_rsp_err    <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            r_psel      <= (w_next == S_SETUP) || (w_next == S_ACCESS);
            r_pen       <= (w_next == S_ACCESS);
            r_rsp_valid <= '0;
            if (w_accept) begin
                r_gnt        <= w_grant;
                r_last_grant <= w_grant;
                r_paddr      <= w_req_addr[w_grant];
                r_wr_en      <= w_req_write[w_grant];
                r_pwdata     <= w_req_wdata[w_grant];
                r_wait       <= '0;
            end
            if (r_state == S_ACCESS) begin
                if (bus.pready) begin
                    r_rsp_valid[r_gnt] <= 1'b1;
                    r_rsp_err[r_gnt]   <= bus.pselverr;
                    r_rsp_rdata[r_gnt] <= (!r_wr_en && !bus.pselverr) ? bus.prdata : '0;
                end else if (w_timeout) begin
                    r_rsp_valid[r_gnt] <= 1'b1;
                    r_rsp_err[r_gnt]   <= 1'b1;
                    r_rsp_rdata[r_gnt] <= '0;
                end else begin
                    r_wait <= w_wait_nxt[CW-1:0];
                end
            end
        end
    end

    assign bus.paddr      = r_paddr;
    assign bus.wr_en      = r_wr_en;
    assign bus.pwdata     = r_pwdata;
    assign bus.psel       = r_psel;
    assign bus.pen        = r_pen;
    assign bus.rsp0_valid = r_rsp_valid[0];
    assign bus.rsp0_err   = r_rsp_err[0];
    assign bus.rsp0_rdata = r_rsp_rdata[0];
    assign bus.rsp1_valid = r_rsp_valid[1];
    assign bus.rsp1_err   = r_rsp_err[1];
    assign bus.rsp1_rdata = r_rsp_rdata[1];
endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Directed bench for apb_ram_arbiter: small APB RAM slave with programmable
// wait states, error and hang, driven by a linear sequence of steps.
module tb_apb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   slv_wait = 0;
    logic slv_err  = 1'b0;
    logic slv_hang = 1'b0;
    int   slv_cnt  = 0;
    logic [31:0] mem [16] = '{default: 32'h0};

    apb_ram_arbiter_if #(.AW(32), .DW(32)) bus ();

    apb_ram_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.pready   = bus.psel && bus.pen && !slv_hang && (slv_cnt == slv_wait);
    assign bus.pselverr = slv_err;
    assign bus.prdata   = slv_err ? 32'hBAD0_BAD0 : mem[bus.paddr[5:2]];

    always @(posedge clk) begin
        if (bus.psel && bus.pen && !bus.pready) slv_cnt <= slv_cnt + 1;
        else                                     slv_cnt <= 0;
        if (bus.psel && bus.pen && bus.pready && bus.wr_en)
            mem[bus.paddr[5:2]] <= bus.pwdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_psel",   32'(bus.psel), 0);
        check("rst_pen",    32'(bus.pen), 0);
        check("rst_paddr",  bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_wr_en",  32'(bus.wr_en), 0);
        check("rst_rsp0",   32'(bus.rsp0_valid), 0);
        check("rst_rsp1",   32'(bus.rsp1_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single write then read, zero-wait slave
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 32'h10; bus.req0_wdata = 32'hDEADBEEF;
        #1;
        check("wr_ready0", 32'(bus.req0_ready), 1);
        check("wr_ready1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        bus.req0_valid = 0;
        #1;
        check("wr_setup_psel", 32'(bus.psel), 1);
        check("wr_setup_pen",  32'(bus.pen), 0);
        check("wr_paddr",      bus.paddr, 32'h10);
        check("wr_wr_en",      32'(bus.wr_en), 1);
        check("wr_pwdata",     bus.pwdata, 32'hDEADBEEF);
        check("wr_ready0_low", 32'(bus.req0_ready), 0);
        @(negedge clk);
        check("wr_access_psel", 32'(bus.psel), 1);
        check("wr_access_pen",  32'(bus.pen), 1);
        check("wr_no_rsp_yet",  32'(bus.rsp0_valid), 0);
        @(negedge clk);
        check("wr_rsp_valid", 32'(bus.rsp0_valid), 1);
        check("wr_rsp_err",   32'(bus.rsp0_err), 0);
        check("wr_rsp_rdata", bus.rsp0_rdata, 0);
        check("wr_resp_psel", 32'(bus.psel), 0);
        check("wr_mem",       mem[4], 32'hDEADBEEF);
        @(negedge clk);
        check("wr_rsp_pulse", 32'(bus.rsp0_valid), 0);
        bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h10; bus.req0_wdata = 0;
        #1;
        check("rd_ready0", 32'(bus.req0_ready), 1);
        @(negedge clk);
        bus.req0_valid = 0;
        check("rd_wr_en", 32'(bus.wr_en), 0);
        @(negedge clk);
        @(negedge clk);
        check("rd_rsp_valid", 32'(bus.rsp0_valid), 1);
        check("rd_rsp_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
        check("rd_rsp_err",   32'(bus.rsp0_err), 0);

        // Contention from reset: client 0 writes, client 1 reads 0x10
        @(negedge clk);
        rst = 1'b1;
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 32'h20; bus.req0_wdata = 32'h1000;
        bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h10; bus.req1_wdata = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("rr_ready0", 32'(bus.req0_ready), (k % 2 == 0) ? 1 : 0);
            check("rr_ready1", 32'(bus.req1_ready), (k % 2 == 1) ? 1 : 0);
            check("rr_no_dual_ready", 32'(bus.req0_ready & bus.req1_ready), 0);
            @(negedge clk);
            if (k % 2 == 0) begin
                bus.req0_addr  = 32'h20 + 32'(4 * (k / 2 + 1));
                bus.req0_wdata = 32'h1000 + 32'(k / 2 + 1);
            end
            @(negedge clk);
            @(negedge clk);
            check("rr_rsp0", 32'(bus.rsp0_valid), (k % 2 == 0) ? 1 : 0);
            check("rr_rsp1", 32'(bus.rsp1_valid), (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) check("rr_rsp1_rdata", bus.rsp1_rdata, 32'hDEADBEEF);
            @(negedge clk);
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        check("rr_mem0", mem[8],  32'h1000);
        check("rr_mem3", mem[11], 32'h1003);

        // Three wait states with slave error
        @(negedge clk);
        slv_wait = 3; slv_err = 1;
        bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h14;
        #1;
        check("ws_ready0", 32'(bus.req0_ready), 1);
        @(negedge clk);
        bus.req0_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ws_psel",  32'(bus.psel), 1);
            check("ws_pen",   32'(bus.pen), 1);
            check("ws_paddr", bus.paddr, 32'h14);
            check("ws_no_rsp", 32'(bus.rsp0_valid), 0);
        end
        @(negedge clk);
        check("ws_rsp_valid", 32'(bus.rsp0_valid), 1);
        check("ws_rsp_err",   32'(bus.rsp0_err), 1);
        check("ws_rsp_rdata", bus.rsp0_rdata, 0);
        check("ws_resp_pen",  32'(bus.pen), 0);
        @(negedge clk);
        slv_wait = 0; slv_err = 0;

        // Timeout: slave never answers
        slv_hang = 1;
        bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 32'h18; bus.req1_wdata = 32'h55;
        #1;
        check("to_ready1", 32'(bus.req1_ready), 1);
        check("to_ready0", 32'(bus.req0_ready), 0);
        @(negedge clk);
        bus.req1_valid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("to_pen",    32'(bus.pen), 1);
            check("to_no_rsp", 32'(bus.rsp1_valid), 0);
        end
        @(negedge clk);
        check("to_rsp_valid", 32'(bus.rsp1_valid), 1);
        check("to_rsp_err",   32'(bus.rsp1_err), 1);
        check("to_rsp_rdata", bus.rsp1_rdata, 0);
        check("to_resp_psel", 32'(bus.psel), 0);
        @(negedge clk);
        slv_hang = 0;
        bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h10;
        #1;
        check("to_next_ready0", 32'(bus.req0_ready), 1);
        @(negedge clk);
        bus.req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("to_next_rdata", bus.rsp0_rdata, 32'hDEADBEEF);
        check("to_next_valid", 32'(bus.rsp0_valid), 1);

        // Reset asserted during client 1's ACCESS
        @(negedge clk);
        slv_hang = 1;
        bus.req1_valid = 1; bus.req1_write = 0; bus.req1_addr = 32'h10;
        #1;
        check("ra_ready1", 32'(bus.req1_ready), 1);
        @(negedge clk);
        bus.req1_valid = 0;
        @(negedge clk);
        check("ra_pen_before", 32'(bus.pen), 1);
        #2 rst = 1'b1;
        #1;
        check("ra_async_psel", 32'(bus.psel), 0);
        check("ra_async_pen",  32'(bus.pen), 0);
        check("ra_no_rsp1",    32'(bus.rsp1_valid), 0);
        bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = 32'h10;
        bus.req1_valid = 1;
        @(negedge clk);
        check("ra_no_rsp1_rst", 32'(bus.rsp1_valid), 0);
        rst = 1'b0;
        slv_hang = 0;
        #1;
        check("ra_ready0", 32'(bus.req0_ready), 1);
        check("ra_ready1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("ra_rsp0", 32'(bus.rsp0_valid), 1);
        check("ra_rsp1", 32'(bus.rsp1_valid), 0);
        check("ra_rsp0_rdata", bus.rsp0_rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
